// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 step sequencer: FSM state encoding and
// the six-step commutation table (phase bit 0 = A, 1 = B, 2 = C).
package motoro3_pkg;

  localparam int unsigned PH_W   = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NSTEPS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RAMP  = 2'd2,
    ST_RUN   = 2'd3
  } seq_state_e;

  // One commutation step: one-hot high-side and low-side phase selects.
  typedef struct packed {
    logic [PH_W-1:0] hi;
    logic [PH_W-1:0] lo;
  } comm_t;

  localparam comm_t COMM_TBL [NSTEPS] = '{
    '{hi: 3'b001, lo: 3'b010},   // 0: A high, B low
    '{hi: 3'b001, lo: 3'b100},   // 1: A high, C low
    '{hi: 3'b010, lo: 3'b100},   // 2: B high, C low
    '{hi: 3'b010, lo: 3'b001},   // 3: B high, A low
    '{hi: 3'b100, lo: 3'b001},   // 4: C high, A low
    '{hi: 3'b100, lo: 3'b010}    // 5: C high, B low
  };

  // Table lookup; illegal indices 6/7 select no phase at all.
  function automatic comm_t comm_lookup(input logic [IDX_W-1:0] idx);
    comm_lookup = '0;
    for (int i = 0; i < int'(NSTEPS); i++) begin
      if (idx == IDX_W'(i)) comm_lookup = COMM_TBL[i];
    end
  endfunction

endpackage

// File: rtl/motoro3_step_timer.sv
// Step-period down-counter.
// Ports: clk/nRst (falling-edge clock, async active-low reset), enable_i (run
// request), state_i (sequencer state), step_len_i (period in clocks),
// cnt_o (current count), last1_o (combinational step-boundary strobe).
module motoro3_step_timer
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             enable_i,
  input  seq_state_e       state_i,
  input  logic [CNT_W-1:0] step_len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last1_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload;

  // Periods below two clocks would collapse the boundary strobe.
  assign reload = (step_len_i < CNT_W'(2)) ? CNT_W'(2) : step_len_i;

  // Next count: clear when stopped, load on IDLE exit, reload after the last clock.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (state_i == ST_IDLE) begin
      cnt_d = reload;
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign last1_o = (cnt_q == CNT_W'(1)) && (state_i != ST_IDLE);

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Six-step BLDC commutation sequencer: IDLE -> ALIGN -> RAMP -> RUN.
// Ports: clk/nRst (falling-edge clock, async active-low reset); m3r_* run
// request, direction and step/ramp configuration; pwm chopping input;
// plLen/m3cnt/m3cntLast1 drive the PWM generator; stepIdx, mosHigh/mosLow
// gate selects (A/B/C) and seqState expose the sequencer state.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W = 25,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3r_enable,
  input  logic             m3r_dir,
  input  logic [CNT_W-1:0] m3r_stepLen,
  input  logic [LEN_W-1:0] m3r_plLenStart,
  input  logic [LEN_W-1:0] m3r_plLenTarget,
  input  logic [LEN_W-1:0] m3r_plLenInc,
  input  logic [3:0]       m3r_alignSteps,
  input  logic             pwm,
  output logic [LEN_W-1:0] plLen,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast1,
  output logic [2:0]       stepIdx,
  output logic [2:0]       mosHigh,
  output logic [2:0]       mosLow,
  output logic [1:0]       seqState
);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] pl_len_q, pl_len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       align_q, align_d;
  logic             boundary;
  logic [LEN_W:0]   ramp_sum;
  logic [IDX_W-1:0] idx_adv;
  comm_t            comm;

  motoro3_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .nRst       (nRst),
    .enable_i   (m3r_enable),
    .state_i    (state_q),
    .step_len_i (m3r_stepLen),
    .cnt_o      (m3cnt),
    .last1_o    (boundary)
  );

  // One extra bit so the ramp sum cannot wrap below the target.
  assign ramp_sum = {1'b0, pl_len_q} + {1'b0, m3r_plLenInc};

  // Mod-6 step advance in the requested direction.
  always_comb begin
    idx_adv = idx_q;
    if (!m3r_dir) idx_adv = (idx_q == IDX_W'(5)) ? '0 : idx_q + IDX_W'(1);
    else          idx_adv = (idx_q == '0) ? IDX_W'(5) : idx_q - IDX_W'(1);
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    pl_len_d = pl_len_q;
    idx_d    = idx_q;
    align_d  = align_q;
    if (!m3r_enable) begin
      state_d  = ST_IDLE;
      pl_len_d = '0;
      idx_d    = '0;
      align_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_ALIGN;
          pl_len_d = m3r_plLenStart;
          idx_d    = '0;
          align_d  = '0;
        end
        ST_ALIGN: begin
          if (boundary) begin
            if (align_q >= m3r_alignSteps) state_d = ST_RAMP;
            else                           align_d = align_q + 4'd1;
          end
        end
        ST_RAMP: begin
          if (boundary) begin
            idx_d = idx_adv;
            if (ramp_sum >= {1'b0, m3r_plLenTarget}) begin
              pl_len_d = m3r_plLenTarget;
              state_d  = ST_RUN;
            end else begin
              pl_len_d = ramp_sum[LEN_W-1:0];
            end
          end
        end
        ST_RUN: begin
          if (boundary) begin
            idx_d    = idx_adv;
            pl_len_d = m3r_plLenTarget;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Recover from an illegal step index regardless of state.
      if (idx_q > IDX_W'(5)) idx_d = '0;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ST_IDLE;
      pl_len_q <= '0;
      idx_q    <= '0;
      align_q  <= '0;
    end else begin
      state_q  <= state_d;
      pl_len_q <= pl_len_d;
      idx_q    <= idx_d;
      align_q  <= align_d;
    end
  end

  // Gate selects come straight from the table, so high and low never share a phase.
  assign comm       = comm_lookup(idx_q);
  assign mosLow     = (state_q == ST_IDLE) ? '0 : comm.lo;
  assign mosHigh    = (state_q == ST_IDLE) ? '0 : (comm.hi & {3{pwm}});
  assign plLen      = pl_len_q;
  assign stepIdx    = idx_q;
  assign m3cntLast1 = boundary;
  assign seqState   = state_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed testbench for motoro3_step_sequencer.
module tb_motoro3_step_sequencer;

  localparam int unsigned CNT_W = 25;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             nRst;
  logic             m3r_enable;
  logic             m3r_dir;
  logic [CNT_W-1:0] m3r_stepLen;
  logic [LEN_W-1:0] m3r_plLenStart;
  logic [LEN_W-1:0] m3r_plLenTarget;
  logic [LEN_W-1:0] m3r_plLenInc;
  logic [3:0]       m3r_alignSteps;
  logic             pwm;
  logic [LEN_W-1:0] plLen;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntLast1;
  logic [2:0]       stepIdx;
  logic [2:0]       mosHigh;
  logic [2:0]       mosLow;
  logic [1:0]       seqState;

  int n_vec = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  motoro3_step_sequencer #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk             (clk),
    .nRst            (nRst),
    .m3r_enable      (m3r_enable),
    .m3r_dir         (m3r_dir),
    .m3r_stepLen     (m3r_stepLen),
    .m3r_plLenStart  (m3r_plLenStart),
    .m3r_plLenTarget (m3r_plLenTarget),
    .m3r_plLenInc    (m3r_plLenInc),
    .m3r_alignSteps  (m3r_alignSteps),
    .pwm             (pwm),
    .plLen           (plLen),
    .m3cnt           (m3cnt),
    .m3cntLast1      (m3cntLast1),
    .stepIdx         (stepIdx),
    .mosHigh         (mosHigh),
    .mosLow          (mosLow),
    .seqState        (seqState)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registers move on the falling edge; sample just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run to the next boundary strobe, then one more clock so its effects are visible.
  task automatic next_boundary(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!m3cntLast1 && cycles < 2000);
    check({tag, "_strobe"}, 32'(m3cntLast1), 32'd1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(seqState), 32'd0);
    check({tag, "_m3cnt"}, 32'(m3cnt), 32'd0);
    check({tag, "_plLen"}, 32'(plLen), 32'd0);
    check({tag, "_idx"},   32'(stepIdx), 32'd0);
    check({tag, "_mosH"},  32'(mosHigh), 32'd0);
    check({tag, "_mosL"},  32'(mosLow), 32'd0);
    check({tag, "_last1"}, 32'(m3cntLast1), 32'd0);
  endtask

  initial begin
    int cyc;
    int ovl;
    int found;

    nRst            = 1'b0;
    m3r_enable      = 1'b0;
    m3r_dir         = 1'b0;
    m3r_stepLen     = '0;
    m3r_plLenStart  = '0;
    m3r_plLenTarget = '0;
    m3r_plLenInc    = '0;
    m3r_alignSteps  = '0;
    pwm             = 1'b1;

    tick();
    tick();
    check_idle_outputs("rst");
    nRst = 1'b1;
    tick();
    tick();
    check_idle_outputs("post_rst");

    // Align + ramp + run at a 100-clock step period.
    m3r_stepLen     = CNT_W'(100);
    m3r_alignSteps  = 4'd1;
    m3r_plLenStart  = LEN_W'(10);
    m3r_plLenInc    = LEN_W'(20);
    m3r_plLenTarget = LEN_W'(50);
    m3r_enable      = 1'b1;
    tick();
    check("start_state", 32'(seqState), 32'd1);
    check("start_m3cnt", 32'(m3cnt), 32'd100);
    check("start_plLen", 32'(plLen), 32'd10);
    check("align_mosH",  32'(mosHigh), 32'b001);
    check("align_mosL",  32'(mosLow), 32'b010);

    next_boundary("b1", cyc);
    check("b1_period", 32'(cyc + 1), 32'd100);
    check("b1_state",  32'(seqState), 32'd1);
    check("b1_idx",    32'(stepIdx), 32'd0);
    next_boundary("b2", cyc);
    check("b2_period", 32'(cyc + 1), 32'd100);
    check("b2_state",  32'(seqState), 32'd2);
    check("b2_idx",    32'(stepIdx), 32'd0);
    check("b2_plLen",  32'(plLen), 32'd10);
    next_boundary("b3", cyc);
    check("b3_state",  32'(seqState), 32'd2);
    check("b3_idx",    32'(stepIdx), 32'd1);
    check("b3_plLen",  32'(plLen), 32'd30);
    next_boundary("b4", cyc);
    check("b4_state",  32'(seqState), 32'd3);
    check("b4_idx",    32'(stepIdx), 32'd2);
    check("b4_plLen",  32'(plLen), 32'd50);
    next_boundary("b5", cyc);
    check("b5_state",  32'(seqState), 32'd3);
    check("b5_idx",    32'(stepIdx), 32'd3);
    check("b5_plLen",  32'(plLen), 32'd50);
    check("b5_mosH",   32'(mosHigh), 32'b010);
    check("b5_mosL",   32'(mosLow), 32'b001);
    pwm = 1'b0;
    #1;
    check("pwm0_mosH", 32'(mosHigh), 32'b000);
    check("pwm0_mosL", 32'(mosLow), 32'b001);
    pwm = 1'b1;

    // Shorter period, forward to step 0, then reverse.
    m3r_stepLen = CNT_W'(10);
    next_boundary("b6", cyc);
    check("b6_idx", 32'(stepIdx), 32'd4);
    next_boundary("b7", cyc);
    check("b7_idx", 32'(stepIdx), 32'd5);
    next_boundary("b8", cyc);
    check("b8_idx", 32'(stepIdx), 32'd0);
    check("b8_period", 32'(cyc + 1), 32'd10);
    m3r_dir = 1'b1;
    next_boundary("b9", cyc);
    check("b9_idx", 32'(stepIdx), 32'd5);
    next_boundary("b10", cyc);
    check("b10_idx",  32'(stepIdx), 32'd4);
    check("b10_mosH", 32'(mosHigh), 32'b100);
    check("b10_mosL", 32'(mosLow), 32'b001);

    // Drop enable mid-step at m3cnt == 37.
    m3r_dir     = 1'b0;
    m3r_stepLen = CNT_W'(100);
    next_boundary("b11", cyc);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (m3cnt == CNT_W'(37)) found = 1;
      else tick();
    end
    check("reach_37", 32'(m3cnt), 32'd37);
    m3r_enable = 1'b0;
    tick();
    check_idle_outputs("drop");

    // Degenerate period and start above target.
    m3r_stepLen     = CNT_W'(0);
    m3r_alignSteps  = 4'd0;
    m3r_plLenStart  = LEN_W'(60);
    m3r_plLenTarget = LEN_W'(50);
    m3r_plLenInc    = LEN_W'(5);
    m3r_enable      = 1'b1;
    tick();
    check("p2_m3cnt", 32'(m3cnt), 32'd2);
    next_boundary("p2a", cyc);
    check("p2a_period", 32'(cyc + 1), 32'd2);
    check("p2a_state",  32'(seqState), 32'd2);
    check("p2a_plLen",  32'(plLen), 32'd60);
    next_boundary("p2b", cyc);
    check("p2b_period", 32'(cyc + 1), 32'd2);
    check("p2b_state",  32'(seqState), 32'd3);
    check("p2b_plLen",  32'(plLen), 32'd50);
    check("p2b_idx",    32'(stepIdx), 32'd1);

    // Random pwm through align and ramp, then reset mid-ramp.
    m3r_enable = 1'b0;
    tick();
    m3r_stepLen     = CNT_W'(20);
    m3r_plLenStart  = LEN_W'(10);
    m3r_plLenInc    = LEN_W'(5);
    m3r_plLenTarget = LEN_W'(200);
    m3r_enable      = 1'b1;
    ovl = 0;
    repeat (150) begin
      tick();
      pwm = 1'($urandom);
      #1;
      if ((mosHigh & mosLow) != 3'b000) ovl++;
    end
    check("no_overlap", 32'(ovl), 32'd0);
    check("mid_ramp_state", 32'(seqState), 32'd2);
    #10;
    nRst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick();
    pwm = 1'b1;
    #1;
    check_idle_outputs("in_rst");
    m3r_enable = 1'b0;
    #10;
    nRst = 1'b1;
    tick();
    tick();
    check_idle_outputs("rst_release");
    m3r_enable = 1'b1;
    tick();
    check("restart_state", 32'(seqState), 32'd1);
    check("restart_m3cnt", 32'(m3cnt), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 25, meaning width of the step-period counter m3cnt.
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the per-step pulse length plLen.
REQ-003 SHALL have port clk, input, 1, meaning the single 10 MHz clock; all registers update on the falling edge.
REQ-004 SHALL have port nRst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port m3r_enable, input, 1, meaning run request.
REQ-006 SHALL have port m3r_dir, input, 1, meaning direction: 0 = step index +1, 1 = step index -1.
REQ-007 SHALL have port m3r_stepLen, input, CNT_W, meaning step period in clocks.
REQ-008 SHALL have ports m3r_plLenStart, m3r_plLenTarget and m3r_plLenInc, input, LEN_W each, meaning ramp start, ramp target and per-step ramp increment.
REQ-009 SHALL have port m3r_alignSteps, input, 4, meaning number of extra align steps.
REQ-010 SHALL have port pwm, input, 1, meaning the chopping output of the PWM generator.
REQ-011 SHALL have outputs plLen (LEN_W), m3cnt (CNT_W) and m3cntLast1 (1), meaning the drive signals of the PWM generator.
REQ-012 SHALL have outputs stepIdx (3), mosHigh (3, phases A/B/C) and mosLow (3), meaning step index and gate selects.
REQ-013 SHALL have output seqState (2), meaning current FSM state.

Function
REQ-014 SHALL implement FSM states IDLE=0, ALIGN=1, RAMP=2 and RUN=3.
REQ-015 SHALL, in IDLE, hold plLen=0, m3cnt=0, stepIdx=0 and alignCnt=0, with all mos outputs 0.
REQ-016 SHALL, in IDLE with m3r_enable=1, go to ALIGN and load m3cnt=max(m3r_stepLen,2) and plLen=m3r_plLenStart.
REQ-017 SHALL, outside IDLE, decrement m3cnt by 1 per clock, and when m3cnt==1 reload it with max(m3r_stepLen,2) sampled that cycle.
REQ-018 SHALL drive m3cntLast1 combinationally as (m3cnt==1) and state!=IDLE; one cycle with m3cntLast1 high is a step boundary.
REQ-019 SHALL, in ALIGN, hold stepIdx; at each boundary, if alignCnt>=m3r_alignSteps go to RAMP, else increment alignCnt; ALIGN therefore lasts m3r_alignSteps+1 steps.
REQ-020 SHALL, in RAMP, at each boundary advance stepIdx per m3r_dir with mod-6 wrap (5->0 and 0->5).
REQ-021 SHALL, in RAMP, compute plLen+m3r_plLenInc in LEN_W+1 bits; if the sum is >= m3r_plLenTarget, set plLen=target and go to RUN, else set plLen to the sum.
REQ-022 SHALL, when m3r_plLenStart >= m3r_plLenTarget, enter RUN at the first RAMP boundary with plLen=target.
REQ-023 SHALL, in RUN, at each boundary advance stepIdx and load plLen=m3r_plLenTarget.
REQ-024 SHALL sample m3r_dir and all config inputs only at boundaries (stepLen also at IDLE exit).
REQ-025 SHALL, when m3r_enable=0 in any state, return to IDLE at the next clock edge; the IDLE values of REQ-015 hold from that edge.
REQ-026 SHALL use commutation steps (high,low) 0:(A,B), 1:(A,C), 2:(B,C), 3:(B,A), 4:(C,A), 5:(C,B), with ALIGN using step 0.
REQ-027 SHALL drive mosLow to the selected low phase, static, and mosHigh to the selected high phase ANDed with pwm; both SHALL be 0 in IDLE.
REQ-028 SHALL never assert mosHigh[k] and mosLow[k] for the same phase k.
REQ-029 SHALL force stepIdx to 0 at the next edge if it holds the illegal value 6 or 7.

Reset
REQ-030 SHALL, on nRst low, asynchronously set state=IDLE, m3cnt=0, plLen=0, stepIdx=0 and alignCnt=0.
REQ-031 SHALL hold all outputs 0 during and after reset until m3r_enable=1 is seen at a falling edge.
REQ-032 SHALL, on reset mid-run, abort the sequence with no completion of the current step.

Structure
REQ-033 SHALL place the FSM state encoding and the 6-entry commutation table constant in shared package motoro3_pkg.
REQ-034 SHALL implement the m3cnt down-counter, reload and m3cntLast1 decode in one sub-module, motoro3_step_timer.

Verification
REQ-035 SHALL cover: stepLen=100, alignSteps=1, enable=1 -> m3cntLast1 pulses every 100 clocks; stepIdx=0 for 2 steps, then 1,2,3...
REQ-036 SHALL cover: start=10, inc=20, target=50 -> plLen 10,30,50 at successive RAMP boundaries; RUN entered with plLen=50.
REQ-037 SHALL cover: dir=1 in RUN from stepIdx=0 -> next boundary gives stepIdx=5, then 4.
REQ-038 SHALL cover: stepLen=0 -> period 2 clocks; start=60, target=50 -> RUN at first RAMP boundary with plLen=50.
REQ-039 SHALL cover: enable dropped mid-step at m3cnt=37 -> next edge gives IDLE with m3cnt=0, plLen=0 and mos outputs=0.
REQ-040 SHALL cover: random pwm with nRst pulsed mid-RAMP -> all outputs 0 immediately, and no same-phase high/low overlap ever.
